// File: rtl/ama_riscv_fetch_pkg.sv
// Shared types and sizes for the instruction fetch stage.
package ama_riscv_fetch_pkg;

   localparam int unsigned CORE_ADDR_BUS_B  = 32;
   localparam int unsigned CORE_ADDR_BUS_W  = CORE_ADDR_BUS_B - 2;
   localparam int unsigned INST_W           = 32;
   localparam int unsigned FETCH_FIFO_DEPTH = 2;
   localparam logic [CORE_ADDR_BUS_B-1:0] FETCH_RESET_PC = 32'h0004_0000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      STALE = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [INST_W-1:0]          inst;
      logic [CORE_ADDR_BUS_B-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/ama_riscv_fetch_fifo.sv
// Small synchronous FIFO holding fetched instructions with their PC toward decode.
module ama_riscv_fetch_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 64
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clear,
   input  logic                         push,
   input  logic                         pop,
   input  logic [WIDTH-1:0]             wdata,
   output logic [WIDTH-1:0]             rdata,
   output logic [$clog2(DEPTH):0]       cnt,
   output logic                         full,
   output logic                         empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // Storage is reset too so the head never shows X toward decode.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   cnt <= cnt + CNT_W'(1);
            2'b01:   cnt <= cnt - CNT_W'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   assign rdata = mem[rd_ptr];
   assign full  = (cnt == CNT_W'(DEPTH));
   assign empty = (cnt == '0);

endmodule

// File: rtl/ama_riscv_fetch.sv
// Instruction fetch: owns the PC, keeps one icache request in flight, buffers
// returned instructions for decode and squashes stale responses on redirect.
module ama_riscv_fetch
   import ama_riscv_fetch_pkg::*;
#(
   parameter logic [CORE_ADDR_BUS_B-1:0] RESET_PC   = FETCH_RESET_PC,
   parameter int unsigned                FIFO_DEPTH = FETCH_FIFO_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst_n,
   output logic                       req_core_valid,
   input  logic                       req_core_ready,
   output logic [CORE_ADDR_BUS_W-1:0] req_core_data,
   input  logic                       rsp_core_valid,
   output logic                       rsp_core_ready,
   input  logic [INST_W-1:0]          rsp_core_data,
   input  logic                       flush_valid,
   input  logic [CORE_ADDR_BUS_B-1:0] flush_pc,
   output logic                       inst_valid,
   input  logic                       inst_ready,
   output logic [INST_W-1:0]          inst_data,
   output logic [CORE_ADDR_BUS_B-1:0] inst_pc
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

   fetch_state_t               state;
   fetch_state_t               state_nxt;
   logic [CORE_ADDR_BUS_B-1:0] pc;
   logic [CORE_ADDR_BUS_B-1:0] req_pc;
   logic                       rsp_accept;
   logic                       fire;
   logic                       credit_ok;
   logic                       fifo_push;
   logic                       fifo_pop;
   logic                       fifo_full;
   logic                       fifo_empty;
   logic [CNT_W-1:0]           fifo_cnt;
   fetch_entry_t               push_entry;
   fetch_entry_t               head_entry;

   assign rsp_core_ready = 1'b1;
   assign rsp_accept     = rsp_core_valid && (state != IDLE);
   assign fifo_push      = rsp_accept && (state == BUSY) && !flush_valid;
   assign fifo_pop       = inst_valid && inst_ready && !flush_valid;
   assign req_core_data  = pc[CORE_ADDR_BUS_B-1:2];

   // Only issue if the answer is guaranteed a slot after this cycle's push/pop.
   always_comb begin
      credit_ok = !fifo_full;
      case ({fifo_push, fifo_pop})
         2'b10:   credit_ok = (fifo_cnt < CNT_W'(FIFO_DEPTH - 1));
         2'b01:   credit_ok = 1'b1;
         default: credit_ok = !fifo_full;
      endcase
   end

   always_comb begin
      state_nxt      = state;
      req_core_valid = 1'b0;
      if (rst_n && !flush_valid && credit_ok)
         req_core_valid = (state == IDLE) || ((state == BUSY) && rsp_accept);
      fire = req_core_valid && req_core_ready;
      case (state)
         IDLE:  if (fire) state_nxt = BUSY;
         BUSY: begin
            if (flush_valid)     state_nxt = rsp_accept ? IDLE : STALE;
            else if (rsp_accept) state_nxt = fire ? BUSY : IDLE;
         end
         STALE: if (rsp_accept) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         pc     <= RESET_PC;
         req_pc <= '0;
      end else begin
         state <= state_nxt;
         if (flush_valid) pc <= flush_pc & ~CORE_ADDR_BUS_B'(3);
         else if (fire)   pc <= pc + CORE_ADDR_BUS_B'(4);
         if (fire) req_pc <= pc;
      end
   end

   always_comb begin
      push_entry.inst = rsp_core_data;
      push_entry.pc   = req_pc;
   end

   ama_riscv_fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(fetch_entry_t))
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (flush_valid),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .wdata (push_entry),
      .rdata (head_entry),
      .cnt   (fifo_cnt),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign inst_valid = !fifo_empty;
   assign inst_data  = head_entry.inst;
   assign inst_pc    = head_entry.pc;

endmodule
